// File: rtl/phase_gen.sv
// phase_gen: turns rising edges of the divided clock (tick) into a one-hot
// ring of PHASES timing pulses, a one-clk frame strobe and a wrapping frame
// counter. Everything runs in the fast clk domain.
// Optional build macro: PHASE_GEN_SYNC_EN adds a 2-flop synchronizer on tick
// (tick-to-phase latency 3 clk instead of 1 clk).
module phase_gen #(
  parameter int PHASES     = 12,
  parameter int FRAME_BITS = 8,
  localparam int IW        = $clog2(PHASES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  output logic [PHASES-1:0]     phase,
  output logic [IW-1:0]         phase_idx,
  output logic                  frame_strobe,
  output logic [FRAME_BITS-1:0] frame_count,
  output logic                  running
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_STOP} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(PHASES - 1);

  state_t                r_state, w_state_nxt;
  logic                  r_tick_q;
  logic                  w_tick, w_adv;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [PHASES-1:0]     r_phase, w_phase_nxt;
  logic                  r_strobe, w_strobe_nxt;
  logic [FRAME_BITS-1:0] r_count, w_count_nxt;
  logic                  r_running, w_run_nxt;

`ifdef PHASE_GEN_SYNC_EN
  logic [1:0] r_sync;

  // two-flop synchronizer for a tick coming from an unrelated domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[0], tick};
  end

  assign w_tick = r_sync[1];
`else
  assign w_tick = tick;
`endif

  // previous tick level; reset low so a tick held high out of reset is an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tick_q <= 1'b0;
    else        r_tick_q <= w_tick;
  end

  assign w_adv = w_tick & ~r_tick_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state plus next ring index, strobe and frame count
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_strobe_nxt = 1'b0;
    w_count_nxt  = r_count;
    unique case (r_state)
      S_IDLE: begin
        w_idx_nxt = '0;
        if (start && !stop) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        w_idx_nxt = '0;
        if (stop)       w_state_nxt = S_IDLE;
        else if (w_adv) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_adv) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt    = '0;
            w_strobe_nxt = 1'b1;
            w_count_nxt  = r_count + FRAME_BITS'(1);
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
        // a stop on the wrap cycle lets the wrap finish and stops next frame
        if (stop) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_adv) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt    = '0;
            w_strobe_nxt = 1'b1;
            w_count_nxt  = r_count + FRAME_BITS'(1);
            w_state_nxt  = S_IDLE;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
        // a fresh start cancels the pending stop and keeps the ring going
        if (start && !stop) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_run_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_STOP);

  // one-hot decode of the next index, blanked when not sequencing
  for (genvar g = 0; g < PHASES; g++) begin : g_dec
    assign w_phase_nxt[g] = w_run_nxt && (w_idx_nxt == IW'(g));
  end

  // registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_phase   <= '0;
      r_strobe  <= 1'b0;
      r_count   <= '0;
      r_running <= 1'b0;
    end else begin
      r_idx     <= w_run_nxt ? w_idx_nxt : '0;
      r_phase   <= w_phase_nxt;
      r_strobe  <= w_strobe_nxt;
      r_count   <= w_count_nxt;
      r_running <= w_run_nxt;
    end
  end

  assign phase        = r_phase;
  assign phase_idx    = r_idx;
  assign frame_strobe = r_strobe;
  assign frame_count  = r_count;
  assign running      = r_running;

endmodule
